gpu_blit_engine: RTL

//  Parametrised 2D fill/blit engine; successor of the linear GPU pixel writer. CPU programs a rectangle
//  (x,y,w,h) over the byte-enabled register bus. Engine emits one addressed pixel beat per cycle into
//  the SDRAM write FIFO via valid/ready. Adds 2D clipping, row stepping, abort, tiled-pattern source,

---
 rtl/gpu_pkg.sv | 56 +++++
 rtl/gpu_blit_regfile.sv | 153 +++++++++++++++
 rtl/gpu_blit_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_pkg
//  Purpose  : Shared definitions for the 2D blit engine: register indices,
//             CTRL/STATUS bit positions, FSM state encoding and a byte-enable
//             merge helper used by the register file.
//  Revision : 1.0  initial release
// ============================================================================
package gpu_pkg;

    // Register word indices
    localparam logic [7:0] c_REG_X      = 8'd0;
    localparam logic [7:0] c_REG_Y      = 8'd1;
    localparam logic [7:0] c_REG_W      = 8'd2;
    localparam logic [7:0] c_REG_H      = 8'd3;
    localparam logic [7:0] c_REG_COLOR  = 8'd4;
    localparam logic [7:0] c_REG_CTRL   = 8'd5;
    localparam logic [7:0] c_REG_STATUS = 8'd6;
    localparam logic [7:0] c_REG_KEY    = 8'd7;
    localparam logic [7:0] c_REG_COUNT  = 8'd8;
    localparam logic [7:0] c_REG_BUF    = 8'd16;

    // CTRL bits
    localparam int c_CTRL_START = 0;
    localparam int c_CTRL_MODE  = 1;
    localparam int c_CTRL_FRAME = 2;
    localparam int c_CTRL_ABORT = 3;

    // STATUS bits
    localparam int c_ST_BUSY    = 0;
    localparam int c_ST_DONE    = 1;
    localparam int c_ST_ABORTED = 2;
    localparam int c_ST_CLIPPED = 3;
    localparam int c_ST_EMPTY   = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_ROW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Replace the bytes of oldVal selected by be with the bytes of newVal.
    function automatic logic [31:0] beMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
        end
        return res;
    endfunction

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/gpu_blit_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_blit_regfile
//  Purpose  : CPU-visible register file of the blit engine. Byte-enabled
//             writes, write masking while the engine is busy (only CTRL.ABORT
//             gets through), self-clearing START/ABORT strobes, and the
//             registered read mux (one cycle latency).
//  Ports    : clk, rstn            clock, async active-low reset
//             i_wrIdx/i_wrBe/i_wrData  write word index, byte enables, data
//             i_rdIdx/o_rdData     read word index, registered read data
//             i_busy/i_status/i_count  engine state fed back for masking/reads
//             o_x..o_frame, o_patBuf  configuration towards the engine
//             o_key                colour key (only with GPU_COLOR_KEY_EN)
//             o_start/o_abort      one-cycle command strobes
//  Macro    : GPU_COLOR_KEY_EN enables the KEY register.
//  Revision : 1.0  initial release
// ============================================================================
module gpu_blit_regfile #(
    parameter int BUF_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [7:0]                  i_wrIdx,
    input  logic [3:0]                  i_wrBe,
    input  logic [31:0]                 i_wrData,
    input  logic [7:0]                  i_rdIdx,
    output logic [31:0]                 o_rdData,
    input  logic                        i_busy,
    input  logic [4:0]                  i_status,
    input  logic [31:0]                 i_count,
    output logic [15:0]                 o_x,
    output logic [15:0]                 o_y,
    output logic [15:0]                 o_w,
    output logic [15:0]                 o_h,
    output logic [23:0]                 o_color,
    output logic                        o_mode,
    output logic                        o_frame,
`ifdef GPU_COLOR_KEY_EN
    output logic [23:0]                 o_key,
`endif
    output logic [BUF_DEPTH-1:0][23:0]  o_patBuf,
    output logic                        o_start,
    output logic                        o_abort
);
    import gpu_pkg::*;

    localparam int c_IDX_W = $clog2(BUF_DEPTH);

    logic [15:0] r_x, r_y, r_w, r_h;
    logic [23:0] r_color;
    logic        r_mode, r_frame;
    logic [23:0] r_patBuf [BUF_DEPTH];
    logic [31:0] r_rdData;
    logic [31:0] w_rdMux;
    logic        w_wrEn, w_cfgWr, w_ctrlWr, w_wrBufHit, w_rdBufHit;
    logic [7:0]  w_wrOff, w_rdOff;
`ifdef GPU_COLOR_KEY_EN
    logic [23:0] r_key;
`endif

    assign w_wrEn     = |i_wrBe;
    assign w_cfgWr    = w_wrEn && !i_busy;
    assign w_ctrlWr   = w_wrEn && (i_wrIdx == c_REG_CTRL) && i_wrBe[0];
    assign w_wrOff    = i_wrIdx - c_REG_BUF;
    assign w_rdOff    = i_rdIdx - c_REG_BUF;
    assign w_wrBufHit = (i_wrIdx >= c_REG_BUF) && (int'(w_wrOff) < BUF_DEPTH);
    assign w_rdBufHit = (i_rdIdx >= c_REG_BUF) && (int'(w_rdOff) < BUF_DEPTH);

    // START is only honoured when idle; ABORT always passes the busy mask.
    assign o_start = w_ctrlWr && i_wrData[c_CTRL_START] && !i_busy;
    assign o_abort = w_ctrlWr && i_wrData[c_CTRL_ABORT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_mode  <= 1'b0;
            r_frame <= 1'b0;
`ifdef GPU_COLOR_KEY_EN
            r_key   <= '0;
`endif
            for (int k = 0; k < BUF_DEPTH; k++) r_patBuf[k] <= '0;
        end else if (w_cfgWr) begin
            case (i_wrIdx)
                c_REG_X:     r_x     <= 16'(beMerge({16'h0, r_x}, i_wrData, i_wrBe));
                c_REG_Y:     r_y     <= 16'(beMerge({16'h0, r_y}, i_wrData, i_wrBe));
                c_REG_W:     r_w     <= 16'(beMerge({16'h0, r_w}, i_wrData, i_wrBe));
                c_REG_H:     r_h     <= 16'(beMerge({16'h0, r_h}, i_wrData, i_wrBe));
                c_REG_COLOR: r_color <= 24'(beMerge({8'h0, r_color}, i_wrData, i_wrBe));
                c_REG_CTRL: begin
                    if (i_wrBe[0]) begin
                        r_mode  <= i_wrData[c_CTRL_MODE];
                        r_frame <= i_wrData[c_CTRL_FRAME];
                    end
                end
`ifdef GPU_COLOR_KEY_EN
                c_REG_KEY:   r_key   <= 24'(beMerge({8'h0, r_key}, i_wrData, i_wrBe));
`endif
                default: begin
                    if (w_wrBufHit) begin
                        r_patBuf[w_wrOff[c_IDX_W-1:0]] <=
                            24'(beMerge({8'h0, r_patBuf[w_wrOff[c_IDX_W-1:0]]}, i_wrData, i_wrBe));
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (i_rdIdx)
            c_REG_X:      w_rdMux = {16'h0, r_x};
            c_REG_Y:      w_rdMux = {16'h0, r_y};
            c_REG_W:      w_rdMux = {16'h0, r_w};
            c_REG_H:      w_rdMux = {16'h0, r_h};
            c_REG_COLOR:  w_rdMux = {8'h0, r_color};
            // START/ABORT are strobes and never read back as set
            c_REG_CTRL:   w_rdMux = {28'h0, 1'b0, r_frame, r_mode, 1'b0};
            c_REG_STATUS: w_rdMux = {27'h0, i_status};
`ifdef GPU_COLOR_KEY_EN
            c_REG_KEY:    w_rdMux = {8'h0, r_key};
`endif
            c_REG_COUNT:  w_rdMux = i_count;
            default:      if (w_rdBufHit) w_rdMux = {8'h0, r_patBuf[w_rdOff[c_IDX_W-1:0]]};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rdData <= '0;
        else       r_rdData <= w_rdMux;
    end

    assign o_rdData = r_rdData;
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_w      = r_w;
    assign o_h      = r_h;
    assign o_color  = r_color;
    assign o_mode   = r_mode;
    assign o_frame  = r_frame;
`ifdef GPU_COLOR_KEY_EN
    assign o_key    = r_key;
`endif

    for (genvar k = 0; k < BUF_DEPTH; k++) begin : g_patOut
        assign o_patBuf[k] = r_patBuf[k];
    end

endmodule : gpu_blit_regfile
`default_nettype wire

// File: rtl/gpu_blit_engine.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_blit_engine
//  Purpose  : 2D fill/blit engine. The CPU programs a rectangle; the engine
//             clips it to the display, then streams one addressed pixel beat
//             per cycle (valid/ready) into the SDRAM write FIFO, row by row.
//  Ports    : clk, rstn                       clock, async active-low reset
//             addrIn/sizeDecode/dataIn        register write (byte enables)
//             addrOut/dataOut                 register read, 1-cycle latency
//             wr_valid/wr_ready/wr_addr/wr_data/wr_last  pixel beat stream
//             irq                             pulse on entry to DONE
//  Macro    : GPU_COLOR_KEY_EN - pattern pixels equal to KEY are skipped.
//  Revision : 1.0  initial release
// ============================================================================
module gpu_blit_engine #(
    parameter int                H_DISP    = 1024,
    parameter int                V_DISP    = 600,
    parameter int                ADDR_W    = 21,
    parameter int                BUF_DEPTH = 16,
    parameter logic [ADDR_W-1:0] FB_BASE0  = 21'h0,
    parameter logic [ADDR_W-1:0] FB_BASE1  = 21'h100000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        addrIn,
    input  logic [3:0]        sizeDecode,
    input  logic [31:0]       dataIn,
    input  logic [7:0]        addrOut,
    output logic [31:0]       dataOut,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              wr_last,
    output logic              irq
);
    import gpu_pkg::*;

    localparam int          c_IDX_W = $clog2(BUF_DEPTH);
    localparam logic [15:0] c_HDISP = 16'(H_DISP);
    localparam logic [15:0] c_VDISP = 16'(V_DISP);

    logic [15:0]               w_x, w_y, w_w, w_h;
    logic [23:0]               w_color;
    logic                      w_mode, w_frame, w_startReq, w_abortReq;
    logic [BUF_DEPTH-1:0][23:0] w_patBuf;
    logic [4:0]                w_status;
    logic                      w_busy;

    state_t            r_state, w_nextState;
    logic [15:0]       r_col, r_row, r_we, r_he, r_lastCol;
    logic [ADDR_W-1:0] r_rowBase;
    logic              r_done, r_aborted, r_clipped, r_empty, r_irq;
    logic [31:0]       r_count;

    logic [15:0]       w_wRoom, w_hRoom, w_we, w_he, w_lastCol;
    logic              w_empty, w_clip, w_anyVis;
    logic [ADDR_W-1:0] w_base;
    logic [23:0]       w_pix;
    logic              w_skip, w_fire, w_beatAcc;
`ifdef GPU_COLOR_KEY_EN
    logic [23:0]       w_key;
    logic [15:0]       w_cand;
`endif

    gpu_blit_regfile #(.BUF_DEPTH(BUF_DEPTH)) u_regfile (
        .clk      (clk),
        .rstn     (rstn),
        .i_wrIdx  (addrIn),
        .i_wrBe   (sizeDecode),
        .i_wrData (dataIn),
        .i_rdIdx  (addrOut),
        .o_rdData (dataOut),
        .i_busy   (w_busy),
        .i_status (w_status),
        .i_count  (r_count),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_w      (w_w),
        .o_h      (w_h),
        .o_color  (w_color),
        .o_mode   (w_mode),
        .o_frame  (w_frame),
`ifdef GPU_COLOR_KEY_EN
        .o_key    (w_key),
`endif
        .o_patBuf (w_patBuf),
        .o_start  (w_startReq),
        .o_abort  (w_abortReq)
    );

    assign w_busy = (r_state == S_SETUP) || (r_state == S_RUN) || (r_state == S_ROW);

    always_comb begin
        w_status               = '0;
        w_status[c_ST_BUSY]    = w_busy;
        w_status[c_ST_DONE]    = r_done;
        w_status[c_ST_ABORTED] = r_aborted;
        w_status[c_ST_CLIPPED] = r_clipped;
        w_status[c_ST_EMPTY]   = r_empty;
    end

    // Rectangle geometry, evaluated during SETUP (config regs are frozen while busy)
    assign w_empty = (w_x >= c_HDISP) || (w_y >= c_VDISP) || (w_w == 16'd0) || (w_h == 16'd0);
    assign w_wRoom = c_HDISP - w_x;
    assign w_hRoom = c_VDISP - w_y;
    assign w_we    = (w_w > w_wRoom) ? w_wRoom : w_w;
    assign w_he    = (w_h > w_hRoom) ? w_hRoom : w_h;
    assign w_clip  = !w_empty && ((w_w > w_wRoom) || (w_h > w_hRoom));
    assign w_base  = (w_frame ? FB_BASE1 : FB_BASE0)
                   + ADDR_W'(w_y) * ADDR_W'(H_DISP) + ADDR_W'(w_x);

    // Column of the final emitted beat in a row. Every row repeats the same
    // pattern, so with keying the last visible column is found by scanning
    // back at most BUF_DEPTH columns from the right edge.
    always_comb begin
        w_lastCol = w_we - 16'd1;
        w_anyVis  = 1'b1;
`ifdef GPU_COLOR_KEY_EN
        w_cand    = '0;
        if (w_mode) begin
            w_anyVis = 1'b0;
            for (int d = BUF_DEPTH - 1; d >= 0; d--) begin
                w_cand = w_we - 16'd1 - 16'(d);
                if ((16'(d) < w_we) && (w_patBuf[w_cand[c_IDX_W-1:0]] != w_key)) begin
                    w_lastCol = w_cand;
                    w_anyVis  = 1'b1;
                end
            end
        end
`endif
    end

    assign w_pix = w_mode ? w_patBuf[r_col[c_IDX_W-1:0]] : w_color;
`ifdef GPU_COLOR_KEY_EN
    assign w_skip = (r_state == S_RUN) && w_mode && (w_pix == w_key);
`else
    assign w_skip = 1'b0;
`endif
    assign wr_valid  = (r_state == S_RUN) && !w_skip;
    assign w_beatAcc = wr_valid && wr_ready;
    assign w_fire    = w_beatAcc || w_skip;
    assign wr_addr   = r_rowBase + ADDR_W'(r_col);
    assign wr_data   = {w_pix, 8'h00};
    assign wr_last   = wr_valid && (r_row == r_he - 16'd1) && (r_col == r_lastCol);
    assign irq       = r_irq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_startReq) w_nextState = S_SETUP;
            S_SETUP: w_nextState = (w_empty || !w_anyVis) ? S_DONE : S_RUN;
            S_RUN: begin
                if (w_abortReq)                          w_nextState = S_DONE;
                else if (w_fire && (r_col == r_we - 16'd1)) w_nextState = S_ROW;
            end
            S_ROW: begin
                if (w_abortReq || (r_row + 16'd1 == r_he)) w_nextState = S_DONE;
                else                                       w_nextState = S_RUN;
            end
            S_DONE:  w_nextState = w_startReq ? S_SETUP : S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col     <= '0;
            r_row     <= '0;
            r_we      <= '0;
            r_he      <= '0;
            r_lastCol <= '0;
            r_rowBase <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_clipped <= 1'b0;
            r_empty   <= 1'b0;
            r_irq     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_irq <= (w_nextState == S_DONE) && (r_state != S_DONE);
            if ((w_nextState == S_DONE) && (r_state != S_DONE)) r_done <= 1'b1;
            // a beat accepted in the same cycle as ABORT still counts
            if (w_beatAcc) r_count <= r_count + 32'd1;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_startReq) begin
                        r_done    <= 1'b0;
                        r_aborted <= 1'b0;
                        r_clipped <= 1'b0;
                        r_empty   <= 1'b0;
                        r_count   <= '0;
                    end
                end
                S_SETUP: begin
                    r_we      <= w_we;
                    r_he      <= w_he;
                    r_lastCol <= w_lastCol;
                    r_rowBase <= w_base;
                    r_col     <= '0;
                    r_row     <= '0;
                    r_clipped <= w_clip;
                    r_empty   <= w_empty;
                end
                S_RUN: begin
                    if (w_abortReq)  r_aborted <= 1'b1;
                    else if (w_fire) r_col     <= r_col + 16'd1;
                end
                S_ROW: begin
                    if (w_abortReq) begin
                        r_aborted <= 1'b1;
                    end else begin
                        r_rowBase <= r_rowBase + ADDR_W'(H_DISP);
                        r_col     <= '0;
                        r_row     <= r_row + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : gpu_blit_engine
`default_nettype wire
